// File: rtl/autoanim_multi.sv
// Multi-channel auto-animation tile counter: per-channel prescaled frame ticks step wrap/ping-pong/one-shot counters.
// Optional macro AUTOANIM_PINGPONG_EN enables true ping-pong (direction bit); otherwise mode 01 behaves as wrap.
module autoanim_multi #(
  parameter int CHANNELS = 2,
  parameter int SPEED_W  = 8,
  parameter int COUNT_W  = 3
) (
  input  logic                          CLK,
  input  logic                          RESETP,
  input  logic                          FRAME_TICK,
  input  logic [CHANNELS*SPEED_W-1:0]   AA_SPEED,
  input  logic [CHANNELS*2-1:0]         AA_MODE,
  input  logic [CHANNELS-1:0]           AA_RESTART,
  output logic [CHANNELS*COUNT_W-1:0]   AA_COUNT,
  output logic [CHANNELS-1:0]           AA_EVENT
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_PP      = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_STOP    = 2'b11
  } aa_mode_e;

  localparam logic [COUNT_W-1:0] MAX = '1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SPEED_W-1:0] w_speed, r_p, w_p_nxt;
    logic [COUNT_W-1:0] r_c, w_c_nxt, w_inc, w_dec;
    logic               r_ev, w_ev_nxt;
    aa_mode_e           w_mode;
`ifdef AUTOANIM_PINGPONG_EN
    logic               r_d, w_d_nxt;
`endif

    assign w_speed = AA_SPEED[c*SPEED_W +: SPEED_W];
    assign w_mode  = aa_mode_e'(AA_MODE[c*2 +: 2]);
    assign w_inc   = r_c + COUNT_W'(1);
    assign w_dec   = r_c - COUNT_W'(1);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      w_p_nxt  = r_p;
      w_c_nxt  = r_c;
      w_ev_nxt = 1'b0;
`ifdef AUTOANIM_PINGPONG_EN
      w_d_nxt  = (w_mode == MODE_PP) ? r_d : 1'b0;
`endif
      if (AA_RESTART[c]) begin
        w_p_nxt = '0;
        w_c_nxt = '0;
`ifdef AUTOANIM_PINGPONG_EN
        w_d_nxt = 1'b0;
`endif
      end else if (FRAME_TICK && w_mode != MODE_STOP) begin
        if (r_p >= w_speed) begin
          w_p_nxt = '0;
          case (w_mode)
`ifdef AUTOANIM_PINGPONG_EN
            MODE_PP: begin
              if (!r_d) begin
                w_c_nxt = w_inc;
                w_d_nxt = (w_inc == MAX);
              end else begin
                w_c_nxt  = w_dec;
                w_d_nxt  = (w_dec != '0);
                w_ev_nxt = (w_dec == '0);
              end
            end
`endif
            MODE_ONESHOT: begin
              if (r_c != MAX) begin
                w_c_nxt  = w_inc;
                w_ev_nxt = (w_inc == MAX);
              end
            end
            default: begin
              // Wrap, and mode 01 when ping-pong is compiled out.
              w_c_nxt  = w_inc;
              w_ev_nxt = (r_c == MAX);
            end
          endcase
        end else begin
          w_p_nxt = r_p + SPEED_W'(1);
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so all channels update from pre-edge values.
    always_ff @(posedge CLK) begin
      if (RESETP) begin
        r_p  <= '0;
        r_c  <= '0;
        r_ev <= 1'b0;
`ifdef AUTOANIM_PINGPONG_EN
        r_d  <= 1'b0;
`endif
      end else begin
        r_p  <= w_p_nxt;
        r_c  <= w_c_nxt;
        r_ev <= w_ev_nxt;
`ifdef AUTOANIM_PINGPONG_EN
        r_d  <= w_d_nxt;
`endif
      end
    end

    assign AA_COUNT[c*COUNT_W +: COUNT_W] = r_c;
    assign AA_EVENT[c]                    = r_ev;
  end

endmodule

// File: tb/tb_autoanim_multi.sv
// Self-checking bench for autoanim_multi: directed sequences on a 2-channel 3-bit instance
// plus a table-driven ping-pong/mode sequence on a 1-channel 2-bit instance.
module tb_autoanim_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [15:0] a_speed;
  logic [3:0]  a_mode;
  logic [1:0]  a_restart;
  logic [5:0]  a_count;
  logic [1:0]  a_event;

  logic       b_tick;
  logic [3:0] b_speed;
  logic [1:0] b_mode;
  logic       b_restart;
  logic [1:0] b_count;
  logic       b_event;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  autoanim_multi #(.CHANNELS(2), .SPEED_W(8), .COUNT_W(3)) dut_a (
    .CLK(clk), .RESETP(rst), .FRAME_TICK(tick),
    .AA_SPEED(a_speed), .AA_MODE(a_mode), .AA_RESTART(a_restart),
    .AA_COUNT(a_count), .AA_EVENT(a_event)
  );

  autoanim_multi #(.CHANNELS(1), .SPEED_W(4), .COUNT_W(2)) dut_b (
    .CLK(clk), .RESETP(rst), .FRAME_TICK(b_tick),
    .AA_SPEED(b_speed), .AA_MODE(b_mode), .AA_RESTART(b_restart),
    .AA_COUNT(b_count), .AA_EVENT(b_event)
  );

  typedef struct {
    logic       restart;
    logic [1:0] mode;
    logic       tick;
    logic [1:0] exp_c;
    logic       exp_e;
  } vec_t;

  vec_t tbl [16];

`ifdef AUTOANIM_PINGPONG_EN
  localparam logic [1:0] EXP_C [16] = '{0,1,2,3,2,1,0,1,2,2,3,2,3,0,0,1};
  localparam logic       EXP_E [16] = '{0,0,0,0,0,0,1,0,0,0,0,0,0,1,0,0};
`else
  localparam logic [1:0] EXP_C [16] = '{0,1,2,3,0,1,2,3,0,0,1,2,3,0,0,1};
  localparam logic       EXP_E [16] = '{0,0,0,0,1,0,0,0,1,0,0,0,0,1,0,0};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input int c0, input int e0, input int c1, input int e1);
    check({name, "_c0"}, a_count[2:0], c0);
    check({name, "_e0"}, a_event[0],   e0);
    check({name, "_c1"}, a_count[5:3], c1);
    check({name, "_e1"}, a_event[1],   e1);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'b01, 1'b1, EXP_C[0],  EXP_E[0]};
    for (int i = 1; i <= 8; i++) tbl[i] = '{1'b0, 2'b01, 1'b1, EXP_C[i], EXP_E[i]};
    tbl[9]  = '{1'b0, 2'b01, 1'b0, EXP_C[9],  EXP_E[9]};
    tbl[10] = '{1'b0, 2'b01, 1'b1, EXP_C[10], EXP_E[10]};
    tbl[11] = '{1'b0, 2'b01, 1'b1, EXP_C[11], EXP_E[11]};
    tbl[12] = '{1'b0, 2'b00, 1'b1, EXP_C[12], EXP_E[12]};
    tbl[13] = '{1'b0, 2'b00, 1'b1, EXP_C[13], EXP_E[13]};
    tbl[14] = '{1'b0, 2'b11, 1'b1, EXP_C[14], EXP_E[14]};
    tbl[15] = '{1'b0, 2'b10, 1'b1, EXP_C[15], EXP_E[15]};

    rst = 1'b1; tick = 1'b0; a_speed = '0; a_mode = 4'b1111; a_restart = '0;
    b_tick = 1'b0; b_speed = '0; b_mode = 2'b11; b_restart = 1'b0;
    #2;
    cyc();
    chk_a("reset", 0, 0, 0, 0);
    check("reset_b_c", b_count, 0);
    check("reset_b_e", b_event, 0);
    rst = 1'b0;

    // Legacy: speed 3, wrap, held tick for 40 cycles; channel 1 stopped.
    a_speed = {8'd0, 8'd3}; a_mode = 4'b1100; tick = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      chk_a("legacy", (n / 4) % 8, (n == 32) ? 1 : 0, 0, 0);
    end
    tick = 1'b0;
    cyc();
    chk_a("legacy_hold", 2, 0, 0, 0);

    // One-shot: speed 1, restart coincident with tick wins.
    a_restart = 2'b01; a_mode[1:0] = 2'b10; a_speed[7:0] = 8'd1; tick = 1'b1;
    cyc();
    chk_a("os_restart", 0, 0, 0, 0);
    a_restart = 2'b00;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      chk_a("oneshot", (n / 2 > 7) ? 7 : n / 2, (n == 14) ? 1 : 0, 0, 0);
    end
    a_restart = 2'b01;
    cyc();
    chk_a("os_restart2", 0, 0, 0, 0);
    a_restart = 2'b00;
    cyc();
    chk_a("os_resume1", 0, 0, 0, 0);
    cyc();
    chk_a("os_resume2", 1, 0, 0, 0);

    // Stop and speed change: P frozen at 5, then speed 2 steps immediately.
    a_restart = 2'b01; a_mode[1:0] = 2'b00; a_speed[7:0] = 8'd9; tick = 1'b0;
    cyc();
    a_restart = 2'b00; tick = 1'b1;
    repeat (5) cyc();
    chk_a("pre_stop", 0, 0, 0, 0);
    a_mode[1:0] = 2'b11;
    for (int n = 0; n < 10; n++) begin
      cyc();
      chk_a("stop", 0, 0, 0, 0);
    end
    a_mode[1:0] = 2'b00; a_speed[7:0] = 8'd2;
    cyc();
    chk_a("speed_chg", 1, 0, 0, 0);
    cyc();
    cyc();
    chk_a("speed_chg_p", 1, 0, 0, 0);
    cyc();
    chk_a("speed_chg_step", 2, 0, 0, 0);

    // Independence: ch0 speed 0, ch1 speed 1; restart ch1 with a tick mid-period.
    a_restart = 2'b11; a_mode = 4'b0000; a_speed = {8'd1, 8'd0}; tick = 1'b0;
    cyc();
    a_restart = 2'b00; tick = 1'b1;
    cyc(); chk_a("ind1", 1, 0, 0, 0);
    cyc(); chk_a("ind2", 2, 0, 1, 0);
    cyc(); chk_a("ind3", 3, 0, 1, 0);
    a_restart = 2'b10;
    cyc(); chk_a("ind_restart", 4, 0, 0, 0);
    a_restart = 2'b00;
    cyc(); chk_a("ind_p_cleared", 5, 0, 0, 0);
    cyc(); chk_a("ind_step", 6, 0, 1, 0);
    cyc(); chk_a("ind7", 7, 0, 1, 0);
    // This tick would wrap ch0 with an event; reset must suppress it.
    rst = 1'b1;
    cyc(); chk_a("mid_reset", 0, 0, 0, 0);
    rst = 1'b0;
    cyc(); chk_a("post_reset1", 1, 0, 0, 0);
    cyc(); chk_a("post_reset2", 2, 0, 1, 0);
    tick = 1'b0;

    // Table-driven ping-pong / mode-change sequence on the 2-bit instance.
    b_speed = 4'd0;
    for (int i = 0; i < 16; i++) begin
      b_restart = tbl[i].restart;
      b_mode    = tbl[i].mode;
      b_tick    = tbl[i].tick;
      cyc();
      check($sformatf("tbl%0d_c", i), b_count, tbl[i].exp_c);
      check($sformatf("tbl%0d_e", i), b_event, tbl[i].exp_e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
